// File: rtl/conv_layer_param_pkg.sv
// Shared types and helpers for the conv layer engines: FSM states, clog2 and
// the saturate/ReLU used when a fixed-point accumulator is narrowed to a word.
package conv_layer_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_LOAD_W,
    S_MAC,
    S_STORE,
    S_FIN
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Clamp to a signed data_size-bit range, then optionally drop negatives.
  function automatic logic signed [63:0] sat_relu(input logic signed [63:0] v,
                                                  input int data_size,
                                                  input bit relu);
    logic signed [63:0] hi, lo, r;
    hi = (64'sd1 <<< (data_size - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_size - 1));
    r  = v;
    if (v > hi) r = hi;
    else if (v < lo) r = lo;
    if (relu && (r < 64'sd0)) r = 64'sd0;
    return r;
  endfunction

endpackage

// File: rtl/conv_layer_param_mac.sv
// Single-stage signed multiply-accumulate with a bias preload; the bias is
// aligned to the product's fixed-point scale on load.
module conv_layer_param_mac #(
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 37
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic signed [DATA_SIZE-1:0] bias,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  output logic signed [ACC_W-1:0]     acc
);

  logic signed [2*DATA_SIZE-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(bias) <<< FRAC_BITS;
    end else if (en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_layer_param.sv
// Parametrised KxKxCin convolution engine: per filter it loads bias and
// weights once, then walks the output map with one MAC per tap.
//
// state   | meaning
// IDLE    | waiting for start
// LOAD_B  | read bias for filter f
// LOAD_W  | stream TAPS weights into the register file
// MAC     | stream TAPS input words and accumulate
// STORE   | write saturated pixel, reload bias
// FIN     | one-cycle done pulse
module conv_layer_param
  import conv_layer_param_pkg::*;
#(
  parameter int DATA_SIZE  = 16,
  parameter int FRAC_BITS  = 8,
  parameter int IMAGE_SIZE = 32,
  parameter int IN_CH      = 1,
  parameter int OUT_CH     = 6,
  parameter int KERNEL     = 5,
  parameter int STRIDE     = 1,
  parameter int RELU_EN    = 1,
  parameter int RD_LAT     = 3,
  parameter int W_BASE     = 0,
  parameter int B_BASE     = 150,
  parameter int R_BASE     = 0,
  parameter int GRAPH_W    = 5,
  parameter int WADDR_W    = 16,
  parameter int IADDR_W    = 14,
  parameter int RADDR_W    = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [GRAPH_W-1:0]   graph,
  output logic                 busy,
  output logic                 done,
  output logic                 wb_ena,
  output logic [WADDR_W-1:0]   wb_addra,
  input  logic [DATA_SIZE-1:0] wb_douta,
  output logic                 in_ena,
  output logic [IADDR_W-1:0]   in_addra,
  input  logic [DATA_SIZE-1:0] in_douta,
  output logic                 res_ena,
  output logic                 res_wea,
  output logic [RADDR_W-1:0]   res_addra,
  output logic [DATA_SIZE-1:0] res_dina
);

  localparam int OUT_SIZE = (IMAGE_SIZE - KERNEL) / STRIDE + 1;
  localparam int TAPS     = KERNEL * KERNEL * IN_CH;
  localparam int ACC_W    = 2 * DATA_SIZE + clog2(TAPS + 1);
  localparam int TW       = clog2(TAPS + 1);
  localparam int OW       = clog2(OUT_SIZE + 1);
  localparam int FW       = clog2(OUT_CH + 1);
  localparam int KW       = clog2(KERNEL + 1);
  localparam int CW       = clog2(IN_CH + 1);

  state_t state, state_nxt;

  logic [GRAPH_W-1:0]      graph_q;
  logic [FW-1:0]           f;
  logic [OW-1:0]           row, col;
  logic [TW-1:0]           iss, rcv;
  logic [KW-1:0]           kr, kc;
  logic [CW-1:0]           ch;
  logic [RD_LAT-1:0]       vld_sr;
  logic [DATA_SIZE-1:0]    w_rf [TAPS];
  logic [DATA_SIZE-1:0]    bias_q;
  logic [WADDR_W-1:0]      wb_addr_q, wb_addr_calc;
  logic [IADDR_W-1:0]      in_addr_q, in_addr_calc;
  logic [RADDR_W-1:0]      res_addr_q, res_addr_calc;
  logic [DATA_SIZE-1:0]    res_data_q, res_data_calc;
  logic signed [ACC_W-1:0] acc;
  logic                    issuing, vld, last_rcv, last_col, last_row, last_f;

  // Returning read data is tracked by a shift register, not by state timing.
  assign vld      = vld_sr[RD_LAT-1];
  assign last_rcv = (rcv == TW'(TAPS - 1));
  assign last_col = (col == OW'(OUT_SIZE - 1));
  assign last_row = (row == OW'(OUT_SIZE - 1));
  assign last_f   = (f == FW'(OUT_CH - 1));

  always_comb begin
    issuing = 1'b0;
    case (state)
      S_LOAD_B:       issuing = (iss == '0);
      S_LOAD_W, S_MAC: issuing = (iss < TW'(TAPS));
      default:        issuing = 1'b0;
    endcase
  end

  assign wb_addr_calc = (state == S_LOAD_B)
      ? WADDR_W'(32'(B_BASE) + 32'(f))
      : WADDR_W'(32'(W_BASE) + 32'(f) * 32'(TAPS) + 32'(iss));
  assign in_addr_calc = IADDR_W'(32'(graph_q) * 32'(IN_CH * IMAGE_SIZE * IMAGE_SIZE)
      + 32'(ch) * 32'(IMAGE_SIZE * IMAGE_SIZE)
      + (32'(row) * 32'(STRIDE) + 32'(kr)) * 32'(IMAGE_SIZE)
      + 32'(col) * 32'(STRIDE) + 32'(kc));
  assign res_addr_calc = RADDR_W'(32'(R_BASE) + 32'(f) * 32'(OUT_SIZE * OUT_SIZE)
      + 32'(row) * 32'(OUT_SIZE) + 32'(col));
  assign res_data_calc = DATA_SIZE'(sat_relu(64'(acc >>> FRAC_BITS), DATA_SIZE, RELU_EN != 0));

  // Addresses follow the live value while issuing and hold the last one otherwise.
  assign wb_ena    = issuing && (state == S_LOAD_B || state == S_LOAD_W);
  assign wb_addra  = wb_ena ? wb_addr_calc : wb_addr_q;
  assign in_ena    = issuing && (state == S_MAC);
  assign in_addra  = in_ena ? in_addr_calc : in_addr_q;
  assign res_ena   = (state == S_STORE);
  assign res_wea   = (state == S_STORE);
  assign res_addra = res_ena ? res_addr_calc : res_addr_q;
  assign res_dina  = res_ena ? res_data_calc : res_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = S_LOAD_B;
      end
      S_LOAD_B: if (vld) state_nxt = S_LOAD_W;
      S_LOAD_W: if (vld && last_rcv) state_nxt = S_MAC;
      S_MAC:    if (vld && last_rcv) state_nxt = S_STORE;
      S_STORE: begin
        if (!(last_col && last_row)) state_nxt = S_MAC;
        else if (!last_f)            state_nxt = S_LOAD_B;
        else                         state_nxt = S_FIN;
      end
      S_FIN: begin
        busy      = 1'b0;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      graph_q    <= '0;
      f          <= '0;
      row        <= '0;
      col        <= '0;
      iss        <= '0;
      rcv        <= '0;
      kr         <= '0;
      kc         <= '0;
      ch         <= '0;
      vld_sr     <= '0;
      bias_q     <= '0;
      wb_addr_q  <= '0;
      in_addr_q  <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      vld_sr <= RD_LAT'({vld_sr, issuing});
      if (wb_ena)  wb_addr_q  <= wb_addra;
      if (in_ena)  in_addr_q  <= in_addra;
      if (res_ena) begin
        res_addr_q <= res_addra;
        res_data_q <= res_dina;
      end
      if (state != state_nxt) begin
        iss <= '0;
        rcv <= '0;
        kr  <= '0;
        kc  <= '0;
        ch  <= '0;
      end else begin
        if (issuing) begin
          iss <= iss + 1'b1;
          if (kc == KW'(KERNEL - 1)) begin
            kc <= '0;
            if (kr == KW'(KERNEL - 1)) begin
              kr <= '0;
              ch <= ch + 1'b1;
            end else begin
              kr <= kr + 1'b1;
            end
          end else begin
            kc <= kc + 1'b1;
          end
        end
        if (vld) rcv <= rcv + 1'b1;
      end
      if (state == S_IDLE && start) begin
        graph_q <= graph;
        f       <= '0;
        row     <= '0;
        col     <= '0;
      end
      if (state == S_LOAD_B && vld) bias_q <= wb_douta;
      if (state == S_STORE) begin
        if (!last_col) begin
          col <= col + 1'b1;
        end else begin
          col <= '0;
          if (!last_row) begin
            row <= row + 1'b1;
          end else begin
            row <= '0;
            if (!last_f) f <= f + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD_W && vld) w_rf[rcv] <= wb_douta;
  end

  conv_layer_param_mac #(
    .DATA_SIZE(DATA_SIZE),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk (clk),
    .rst (rst),
    .load((state == S_LOAD_B && vld) || state == S_STORE),
    .bias((state == S_LOAD_B) ? wb_douta : bias_q),
    .en  (state == S_MAC && vld),
    .a   (in_douta),
    .b   (w_rf[rcv]),
    .acc (acc)
  );

endmodule

// File: tb/tb_conv_layer_param.sv
// Bench for conv_layer_param: two instances (ReLU off/on) on shared BRAM
// models, results checked against a direct arithmetic convolution.
module tb_conv_layer_param;

  localparam int IMG  = 8;
  localparam int ICH  = 3;
  localparam int OCH  = 2;
  localparam int K    = 3;
  localparam int STR  = 2;
  localparam int RDL  = 3;
  localparam int BB   = 150;
  localparam int OS   = (IMG - K) / STR + 1;
  localparam int TAPS = K * K * ICH;
  localparam int NPIX = OCH * OS * OS;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [4:0]  graph = '0;
  logic        busy[2], done[2], wb_ena[2], in_ena[2], res_ena[2], res_wea[2];
  logic [15:0] wb_addra[2], wb_douta[2], in_douta[2], res_dina[2];
  logic [13:0] in_addra[2];
  logic [12:0] res_addra[2];

  logic [15:0] wmem[0:255];
  logic [15:0] imem[0:511];
  logic [15:0] wpipe[2][RDL];
  logic [15:0] ipipe[2][RDL];
  logic [31:0] wq0[$];
  logic [31:0] wq1[$];
  int          done_cnt[2] = '{0, 0};
  logic        pend = 1'b0;
  logic [13:0] first_in = '0;
  int          n_assert = 0, n_fail = 0;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    conv_layer_param #(
      .DATA_SIZE(16), .FRAC_BITS(8), .IMAGE_SIZE(IMG), .IN_CH(ICH), .OUT_CH(OCH),
      .KERNEL(K), .STRIDE(STR), .RELU_EN(d), .RD_LAT(RDL), .W_BASE(0), .B_BASE(BB),
      .R_BASE(0), .GRAPH_W(5), .WADDR_W(16), .IADDR_W(14), .RADDR_W(13)
    ) dut (
      .clk(clk), .rst(rst), .start(start), .graph(graph),
      .busy(busy[d]), .done(done[d]),
      .wb_ena(wb_ena[d]), .wb_addra(wb_addra[d]), .wb_douta(wb_douta[d]),
      .in_ena(in_ena[d]), .in_addra(in_addra[d]), .in_douta(in_douta[d]),
      .res_ena(res_ena[d]), .res_wea(res_wea[d]), .res_addra(res_addra[d]),
      .res_dina(res_dina[d])
    );
    assign wb_douta[d] = wpipe[d][RDL-1];
    assign in_douta[d] = ipipe[d][RDL-1];
  end

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int k = RDL - 1; k > 0; k--) begin
        wpipe[d][k] <= wpipe[d][k-1];
        ipipe[d][k] <= ipipe[d][k-1];
      end
      wpipe[d][0] <= wb_ena[d] ? wmem[wb_addra[d][7:0]] : 16'hDEAD;
      ipipe[d][0] <= in_ena[d] ? imem[in_addra[d][8:0]] : 16'hDEAD;
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
    end
    if (res_ena[0] && res_wea[0]) wq0.push_back({3'b0, res_addra[0], res_dina[0]});
    if (res_ena[1] && res_wea[1]) wq1.push_back({3'b0, res_addra[1], res_dina[1]});
    if (start && !busy[0]) pend <= 1'b1;
    else if (pend && in_ena[0]) begin
      first_in <= in_addra[0];
      pend     <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Modes: 0 unit, 1 weights -1.0, 2 +max sat, 3 -max sat, 4 ramp, 5 random, 6 wide random
  task automatic fill(input int mode);
    for (int i = 0; i < 256; i++) wmem[i] = '0;
    for (int i = 0; i < 512; i++) begin
      case (mode)
        0, 1:    imem[i] = 16'h0100;
        2, 3:    imem[i] = 16'h7FFF;
        4:       imem[i] = 16'((i % 64) * 16);
        5:       imem[i] = 16'($urandom_range(0, 1023)) - 16'd512;
        default: imem[i] = 16'($urandom);
      endcase
    end
    for (int i = 0; i < OCH * TAPS; i++) begin
      case (mode)
        0, 4:    wmem[i] = 16'h0100;
        1:       wmem[i] = 16'hFF00;
        2:       wmem[i] = 16'h7FFF;
        3:       wmem[i] = 16'h8000;
        5:       wmem[i] = 16'($urandom_range(0, 255)) - 16'd128;
        default: wmem[i] = 16'($urandom);
      endcase
    end
    for (int f = 0; f < OCH; f++) begin
      if (mode >= 4) wmem[BB+f] = 16'($urandom_range(0, 8191)) - 16'd4096;
    end
  endtask

  function automatic longint ref_val(input int g, input int p);
    int f, r, c;
    longint acc, x, y;
    f = p / (OS * OS);
    r = (p / OS) % OS;
    c = p % OS;
    acc = longint'($signed(wmem[BB+f])) * 256;
    for (int ch = 0; ch < ICH; ch++)
      for (int kr = 0; kr < K; kr++)
        for (int kc = 0; kc < K; kc++) begin
          x = longint'($signed(imem[g*ICH*IMG*IMG + ch*IMG*IMG + (r*STR+kr)*IMG + c*STR + kc]));
          y = longint'($signed(wmem[f*TAPS + (ch*K+kr)*K + kc]));
          acc += x * y;
        end
    acc = acc >>> 8;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
  endfunction

  task automatic check_map(input string tag, input int g, input int b0, input int b1);
    longint v;
    logic [15:0] lin, rl;
    chk({tag, "_nwr0"}, 32'(wq0.size() - b0), 32'(NPIX));
    chk({tag, "_nwr1"}, 32'(wq1.size() - b1), 32'(NPIX));
    for (int p = 0; p < NPIX; p++) begin
      v   = ref_val(g, p);
      lin = v[15:0];
      rl  = (v < 0) ? 16'h0000 : v[15:0];
      if (b0 + p < wq0.size()) begin
        chk($sformatf("%s_addr0_%0d", tag, p), 32'(wq0[b0+p][28:16]), 32'(p));
        chk($sformatf("%s_data0_%0d", tag, p), 32'(wq0[b0+p][15:0]), 32'(lin));
      end
      if (b1 + p < wq1.size()) begin
        chk($sformatf("%s_addr1_%0d", tag, p), 32'(wq1[b1+p][28:16]), 32'(p));
        chk($sformatf("%s_data1_%0d", tag, p), 32'(wq1[b1+p][15:0]), 32'(rl));
      end
    end
  endtask

  task automatic wait_done(input string tag);
    int cyc = 0;
    while (done[0] !== 1'b1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done"}, 32'(done[0]), 32'd1);
  endtask

  task automatic run_map(input string tag, input logic [4:0] g);
    @(negedge clk);
    graph = g;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(tag);
    @(negedge clk);
    chk({tag, "_busy0_after"}, 32'(busy[0]), 32'd0);
    chk({tag, "_busy1_after"}, 32'(busy[1]), 32'd0);
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    chk({tag, "_busy"},      32'(busy[d]),      32'd0);
    chk({tag, "_done"},      32'(done[d]),      32'd0);
    chk({tag, "_wb_ena"},    32'(wb_ena[d]),    32'd0);
    chk({tag, "_in_ena"},    32'(in_ena[d]),    32'd0);
    chk({tag, "_res_ena"},   32'(res_ena[d]),   32'd0);
    chk({tag, "_res_wea"},   32'(res_wea[d]),   32'd0);
    chk({tag, "_wb_addra"},  32'(wb_addra[d]),  32'd0);
    chk({tag, "_in_addra"},  32'(in_addra[d]),  32'd0);
    chk({tag, "_res_addra"}, 32'(res_addra[d]), 32'd0);
    chk({tag, "_res_dina"},  32'(res_dina[d]),  32'd0);
  endtask

  initial begin
    int b0, b1, dc, n, cyc;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst0", 0);
    check_idle_outputs("rst1", 1);
    rst = 1'b1;

    for (int mode = 0; mode < 7; mode++) begin
      fill(mode);
      b0 = wq0.size();
      b1 = wq1.size();
      dc = done_cnt[0];
      run_map($sformatf("mode%0d", mode), 5'd0);
      check_map($sformatf("mode%0d", mode), 0, b0, b1);
      chk($sformatf("mode%0d_done_cnt", mode), 32'(done_cnt[0] - dc), 32'd1);
    end

    // Abort during the second filter, then rerun the whole map.
    fill(5);
    b0 = wq0.size();
    @(negedge clk);
    graph = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (wq0.size() < b0 + OS * OS + 1 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reach_f1", 32'(wq0.size() >= b0 + OS * OS + 1), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("abort", 0);
    @(negedge clk);
    rst = 1'b1;
    n = wq0.size();
    repeat (100) @(negedge clk);
    chk("abort_no_writes", 32'(wq0.size() - n), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    b0 = wq0.size();
    b1 = wq1.size();
    run_map("rerun", 5'd0);
    check_map("rerun", 0, b0, b1);

    // start while busy and on the done cycle is ignored; one cycle later is accepted.
    fill(6);
    b0 = wq0.size();
    b1 = wq1.size();
    dc = done_cnt[0];
    @(negedge clk);
    graph = 5'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    graph = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("back1");
    start = 1'b1;
    @(negedge clk);
    chk("fin_start_ignored", 32'(busy[0]), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("idle_start_taken", 32'(busy[0]), 32'd1);
    check_map("back1", 0, b0, b1);
    wait_done("back2");
    @(negedge clk);
    check_map("back2", 1, b0 + NPIX, b1 + NPIX);
    chk("graph1_first_in", 32'(first_in), 32'(ICH * IMG * IMG));
    chk("back_done_cnt", 32'(done_cnt[0] - dc), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
